program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PC_W, default 4, SHALL set the program counter width (program depth 2^PC_W).
REQ-002 Parameter END_ADDR, default 2^PC_W-1, SHALL set the last program address executed.
REQ-003 CLKin  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL be the run request, sampled only in IDLE or DONE.
REQ-006 stepMode  input  1  SHALL, when 1, pause after every executed instruction.
REQ-007 step  input  1  SHALL be the single-cycle pulse that releases PAUSE.
REQ-008 loop  input  1  SHALL, when 1, wrap to address 0 after END_ADDR instead of finishing.
REQ-009 instrIn  input  4  SHALL be the program memory read data, valid one cycle after pc changes.
REQ-010 pc  output  PC_W  SHALL be the program memory address.
REQ-011 opcode  output  4  SHALL be the instruction register, driving the instruction decoder.
REQ-012 opValid  output  1  SHALL be a one-cycle execute strobe qualifying opcode for decoder and datapath enables.
REQ-013 busy  output  1  SHALL be 1 in every state except IDLE and DONE.
REQ-014 done  output  1  SHALL be 1 only in DONE.

Function
REQ-015 States SHALL be IDLE, FETCH, LATCH, EXEC, PAUSE, DONE.
REQ-016 IDLE: start=1 -> FETCH with pc=0; otherwise hold.
REQ-017 FETCH: present pc; unconditional -> LATCH next cycle.
REQ-018 LATCH: capture instrIn into opcode; -> EXEC.
REQ-019 EXEC: opValid=1 for exactly this cycle; opcode stable throughout.
REQ-020 EXEC exit, stepMode=1: -> PAUSE, pc unchanged.
REQ-021 EXEC exit, stepMode=0: pc<END_ADDR -> pc+1, FETCH; pc==END_ADDR and loop=1 -> pc=0, FETCH; pc==END_ADDR and loop=0 -> DONE, pc held.
REQ-022 PAUSE: step=1 -> same advance rule as REQ-021; step=0 -> hold; opValid=0.
REQ-023 DONE: start=1 -> FETCH with pc=0; otherwise hold; opcode retains the last instruction.
REQ-024 Throughput SHALL be exactly 3 cycles per instruction with stepMode=0 (FETCH, LATCH, EXEC).
REQ-025 start while busy SHALL be ignored; step outside PAUSE SHALL be ignored.
REQ-026 pc increment SHALL be modulo 2^PC_W; no carry out; END_ADDR=2^PC_W-1 wraps naturally to 0 when loop=1.
REQ-027 A stepMode change SHALL take effect at the next EXEC exit only.
REQ-028 opValid SHALL never be asserted for two consecutive cycles.

Reset
REQ-029 RSTn=0 at a rising edge SHALL force IDLE, pc=0, opcode=0, opValid=0, busy=0, done=0 in any state, including mid-EXEC.
REQ-030 An instruction in flight at reset SHALL be abandoned; no opValid after the reset edge.

Structure
REQ-031 State encoding and the PC_W default SHALL live in the shared control package.
REQ-032 A single sub-module, pc_counter (load-zero, increment, hold), is natural; the rest is one FSM.

Verification
REQ-033 Program 0..15 = opcodes 0..15, start pulse, stepMode=0, loop=0 -> 16 opValid strobes 3 cycles apart, opcode sequence 0..15, done=1 on cycle 49 after start.
REQ-034 END_ADDR=3, loop=1 -> opcode sequence 0,1,2,3,0,1,... and done never asserts.
REQ-035 stepMode=1 -> one opValid, then PAUSE held for 10 cycles with pc=0; step pulse -> pc=1, next opValid 3 cycles later.
REQ-036 RSTn=0 during the EXEC of address 5 -> next cycle: IDLE, pc=0, opValid=0, busy=0.
REQ-037 start pulsed while busy at pc=2 -> no restart; sequence continues at pc=3.
REQ-038 From DONE, start=1 -> pc=0, FETCH; done deasserts next cycle.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared control package for the program sequencer: state encoding and
// default widths used by the sequencer, its interface and sub-module.
package program_sequencer_pkg;

  localparam int PC_W_DEF = 4;
  localparam int OPC_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Control/program-memory bundle between the sequencer and its environment.
// The sequencer side uses the slave modport; the driving side uses master.
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic             start;
  logic             stepMode;
  logic             step;
  logic             loop;
  logic [OPC_W-1:0] instrIn;
  logic [PC_W-1:0]  pc;
  logic [OPC_W-1:0] opcode;
  logic             opValid;
  logic             busy;
  logic             done;

  modport master (
    output start, stepMode, step, loop, instrIn,
    input  pc, opcode, opValid, busy, done
  );

  modport slave (
    input  start, stepMode, step, loop, instrIn,
    output pc, opcode, opValid, busy, done
  );

endinterface

// File: rtl/program_sequencer_pc_counter.sv
// Program counter: clear to zero, increment modulo 2^PC_W, or hold.
// Clear wins over increment.
module pc_counter
  import program_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Counter register; natural wrap on increment, no carry out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: walks a program memory from address 0 to END_ADDR,
// three cycles per instruction, with optional single-step and loop modes.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   FETCH | pc presented to program memory
//   LATCH | memory data captured into opcode
//   EXEC  | opValid strobe, decide advance or pause
//   PAUSE | single-step hold until a step pulse
//   DONE  | program finished, opcode keeps last instruction
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int END_ADDR = 2**PC_W - 1
) (
  input  logic              CLKin,
  input  logic              RSTn,
  program_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(END_ADDR);

  state_t           state;
  state_t           state_nxt;
  logic             pc_clr;
  logic             pc_inc;
  logic             advance;
  logic [PC_W-1:0]  pc;
  logic [OPC_W-1:0] opcode;

  pc_counter #(.PC_W(PC_W)) u_pc_counter (
    .clk   (CLKin),
    .rst_n (RSTn),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge CLKin) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register, loaded only in LATCH so it is stable through EXEC
  // and retains the last instruction in DONE.
  always_ff @(posedge CLKin) begin
    if (!RSTn) begin
      opcode <= '0;
    end else if (state == ST_LATCH) begin
      opcode <= bus.instrIn;
    end
  end

  // Next-state and pc control; EXEC (free-running) and PAUSE (on step)
  // share one advance rule.
  always_comb begin
    state_nxt = state;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    advance   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt = ST_FETCH;
          pc_clr    = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (bus.stepMode) begin
          state_nxt = ST_PAUSE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.step) begin
          advance = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (advance) begin
      if (pc != LAST_ADDR) begin
        state_nxt = ST_FETCH;
        pc_inc    = 1'b1;
      end else if (bus.loop) begin
        state_nxt = ST_FETCH;
        pc_clr    = 1'b1;
      end else begin
        state_nxt = ST_DONE;
      end
    end
  end

  assign bus.pc      = pc;
  assign bus.opcode  = opcode;
  assign bus.opValid = (state == ST_EXEC);
  assign bus.busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done    = (state == ST_DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (full-depth program and a
// four-instruction program) compared every cycle against a phase-counting
// reference model, plus literal expectations for the directed scenarios.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int PC_W = 4;

  logic CLKin = 1'b0;
  always #5 CLKin = ~CLKin;

  logic rst_n;
  logic start;
  logic step_mode;
  logic step;
  logic loop;
  logic [3:0] mem [16];
  logic [3:0] instr0;
  logic [3:0] instr1;

  program_sequencer_if #(.PC_W(PC_W)) bus0 ();
  program_sequencer_if #(.PC_W(PC_W)) bus1 ();

  assign bus0.start    = start;
  assign bus0.stepMode = step_mode;
  assign bus0.step     = step;
  assign bus0.loop     = loop;
  assign bus0.instrIn  = instr0;
  assign bus1.start    = start;
  assign bus1.stepMode = step_mode;
  assign bus1.step     = step;
  assign bus1.loop     = loop;
  assign bus1.instrIn  = instr1;

  program_sequencer #(.PC_W(PC_W)) dut0 (
    .CLKin (CLKin),
    .RSTn  (rst_n),
    .bus   (bus0)
  );

  program_sequencer #(.PC_W(PC_W), .END_ADDR(3)) dut1 (
    .CLKin (CLKin),
    .RSTn  (rst_n),
    .bus   (bus1)
  );

  // synchronous program memory, one cycle read latency
  always @(posedge CLKin) begin
    instr0 <= mem[bus0.pc];
    instr1 <= mem[bus1.pc];
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: running flag, phase within the 3-cycle instruction,
  // paused flag, current address and last latched instruction.
  int run_m [2] = '{0, 0};
  int fin_m [2] = '{0, 0};
  int pc_m  [2] = '{0, 0};
  int ph_m  [2] = '{0, 0};
  int pz_m  [2] = '{0, 0};
  int op_m  [2] = '{0, 0};

  task automatic model_advance(input int k, input int last);
    pz_m[k] = 0;
    ph_m[k] = 0;
    if (pc_m[k] < last) pc_m[k] = pc_m[k] + 1;
    else if (loop) pc_m[k] = 0;
    else begin
      run_m[k] = 0;
      fin_m[k] = 1;
    end
  endtask

  task automatic model_tick(input int k, input int last);
    if (!rst_n) begin
      run_m[k] = 0; fin_m[k] = 0; pc_m[k] = 0;
      ph_m[k] = 0;  pz_m[k] = 0;  op_m[k] = 0;
    end else if (run_m[k] == 0) begin
      if (start) begin
        run_m[k] = 1; fin_m[k] = 0; pc_m[k] = 0; ph_m[k] = 0; pz_m[k] = 0;
      end
    end else if (pz_m[k] != 0) begin
      if (step) model_advance(k, last);
    end else if (ph_m[k] == 2) begin
      if (step_mode) pz_m[k] = 1;
      else model_advance(k, last);
    end else begin
      if (ph_m[k] == 1) op_m[k] = int'(mem[pc_m[k]]);
      ph_m[k] = ph_m[k] + 1;
    end
  endtask

  always @(posedge CLKin) begin
    model_tick(0, 15);
    model_tick(1, 3);
  end

  task automatic cmp(input int k, input logic [3:0] p, input logic [3:0] o,
                     input logic v, input logic b, input logic d);
    int exp_v;
    exp_v = (run_m[k] != 0 && pz_m[k] == 0 && ph_m[k] == 2) ? 1 : 0;
    check($sformatf("m%0d_pc", k), int'(p), pc_m[k]);
    check($sformatf("m%0d_opcode", k), int'(o), op_m[k]);
    check($sformatf("m%0d_opValid", k), int'(v), exp_v);
    check($sformatf("m%0d_busy", k), int'(b), run_m[k]);
    check($sformatf("m%0d_done", k), int'(d), fin_m[k]);
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge CLKin) begin
    if (chk_en) begin
      cmp(0, bus0.pc, bus0.opcode, bus0.opValid, bus0.busy, bus0.done);
      cmp(1, bus1.pc, bus1.opcode, bus1.opValid, bus1.busy, bus1.done);
    end
  end

  task automatic pulse_start();
    @(negedge CLKin); start = 1'b1;
    @(negedge CLKin); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLKin); rst_n = 1'b0;
    repeat (2) @(negedge CLKin);
    rst_n = 1'b1;
  endtask

  initial begin
    int edges;
    int done_at;
    int n;
    int k;
    int any_done;
    int opq[$];
    int eq[$];

    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; loop = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    repeat (3) @(posedge CLKin);
    chk_en = 1'b1;

    // reset state
    @(negedge CLKin);
    check("rst_pc", int'(bus0.pc), 0);
    check("rst_opcode", int'(bus0.opcode), 0);
    check("rst_opValid", int'(bus0.opValid), 0);
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_done", int'(bus0.done), 0);
    rst_n = 1'b1;

    // full program 0..15, no loop
    pulse_start();
    edges = 1; done_at = 0;
    while (done_at == 0 && edges < 200) begin
      if (bus0.opValid) begin
        opq.push_back(int'(bus0.opcode));
        eq.push_back(edges);
      end
      if (bus0.done) done_at = edges;
      if (done_at == 0) begin
        @(negedge CLKin);
        edges++;
      end
    end
    check("a_done_cycle", done_at, 49);
    check("a_strobe_count", opq.size(), 16);
    foreach (opq[i]) check($sformatf("a_opcode_%0d", i), opq[i], i);
    for (int i = 1; i < eq.size(); i++) check("a_strobe_gap", eq[i] - eq[i-1], 3);
    check("a_done_opcode", int'(bus0.opcode), 15);

    // restart from DONE
    pulse_start();
    check("b_pc", int'(bus0.pc), 0);
    check("b_busy", int'(bus0.busy), 1);
    check("b_done", int'(bus0.done), 0);
    do_reset();

    // END_ADDR=3 with loop
    loop = 1'b1;
    pulse_start();
    k = 0; any_done = 0;
    repeat (60) begin
      @(negedge CLKin);
      if (bus1.opValid) begin
        check("c_loop_opcode", int'(bus1.opcode), k % 4);
        k++;
      end
      if (bus1.done) any_done = 1;
    end
    check("c_done_never", any_done, 0);
    check("c_enough_strobes", (k >= 16) ? 1 : 0, 1);
    loop = 1'b0;
    do_reset();

    // single-step mode
    step_mode = 1'b1;
    pulse_start();
    n = 0;
    while (!bus0.opValid && n < 10) begin
      @(negedge CLKin);
      n++;
    end
    check("d_first_strobe", int'(bus0.opValid), 1);
    repeat (10) begin
      @(negedge CLKin);
      check("d_pause_pc", int'(bus0.pc), 0);
      check("d_pause_opValid", int'(bus0.opValid), 0);
      check("d_pause_busy", int'(bus0.busy), 1);
    end
    step = 1'b1;
    n = 0;
    do begin
      @(negedge CLKin);
      n++;
      if (n == 1) begin
        step = 1'b0;
        check("d_pc_after_step", int'(bus0.pc), 1);
      end
    end while (!bus0.opValid && n < 10);
    check("d_step_to_strobe", n, 3);
    step_mode = 1'b0;
    do_reset();

    // reset during EXEC of address 5
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    pulse_start();
    n = 0;
    while (!(bus0.opValid && bus0.pc == 4'd5) && n < 100) begin
      @(negedge CLKin);
      n++;
    end
    check("e_reach_exec5", (bus0.opValid && bus0.pc == 4'd5) ? 1 : 0, 1);
    rst_n = 1'b0;
    @(negedge CLKin);
    check("e_pc", int'(bus0.pc), 0);
    check("e_opValid", int'(bus0.opValid), 0);
    check("e_busy", int'(bus0.busy), 0);
    check("e_done", int'(bus0.done), 0);
    check("e_opcode", int'(bus0.opcode), 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge CLKin);
      check("e_no_strobe", int'(bus0.opValid), 0);
    end

    // start while busy is ignored
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    pulse_start();
    n = 0;
    while (bus0.pc != 4'd2 && n < 50) begin
      @(negedge CLKin);
      n++;
    end
    check("f_reach_pc2", int'(bus0.pc), 2);
    start = 1'b1;
    @(negedge CLKin);
    start = 1'b0;
    n = 0;
    while (bus0.pc == 4'd2 && n < 10) begin
      @(negedge CLKin);
      n++;
    end
    check("f_next_pc", int'(bus0.pc), 3);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    repeat (3000) begin
      @(negedge CLKin);
      start = ($urandom_range(0, 7) == 0);
      step  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) loop = ~loop;
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge CLKin);
    rst_n = 1'b1; start = 1'b0; step = 1'b0;
    repeat (2) @(negedge CLKin);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
